display_arbiter: RTL and testbench
==================================

# display_arbiter

Time-shares the 8-digit seven-segment driver between up to N_REQ independent value sources. Sits directly upstream of the driver and feeds its 32-bit data and enable inputs. A round-robin scheduler gives each requesting source the display for a fixed dwell time, with a blank gap between pages. A hold input freezes the current page for inspection.

## Interface
Parameters:
- N_REQ, 4: number of requesters; legal range 2..8.
- DWELL_CYCLES, 100_000_000: clock cycles one page is shown before rotation is considered; must be at least 2.
- BLANK_CYCLES, 10_000_000: clock cycles the display is blanked between different pages; must be at least 1.

Ports:
- clock, in, 1: system clock; the block's only clock.
- reset, in, 1: synchronous, active-high reset.
- req, in, N_REQ: level request per source; bit i = source i wants the display.
- data_in, in, 32*N_REQ: source i's value on bits [32*i+31 : 32*i].
- hold, in, 1: while high, the dwell counter is frozen.
- disp_data, out, 32: value to the seven-segment driver.
- disp_enable, out, 1: enable to the seven-segment driver.
- grant, out, N_REQ: one-hot current owner; all zero when there is no owner.
- owner_id, out, $clog2(N_REQ): index of the current or last owner.
- switch_pulse, out, 1: one-cycle pulse on the first cycle of a new grant.

## Operation
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, on `reset`.
- Reset values: state=IDLE, grant=0, owner_id=0, rr_ptr=0, dwell counter=0, blank counter=0, disp_enable=0, disp_data=32'hFFFF_FFFF, switch_pulse=0.
- Output style: all outputs are registered.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo N_REQ. The first set req bit wins.
  - On each grant, rr_ptr <= (winner+1) mod N_REQ.
- States:
  - IDLE: grant=0, disp_enable=0, disp_data=FFFF_FFFF.
    - Any req bit set → SHOW with the arbitration winner.
  - SHOW: grant/owner_id hold the owner, disp_enable=1, disp_data <= owner's data_in slice every cycle.
    - The dwell counter increments every cycle unless hold=1.
    - Owner's req drops → BLANK. This applies regardless of hold or counter value.
    - Counter reaches DWELL_CYCLES-1 with hold=0 and some other req bit set → BLANK.
    - Counter reaches DWELL_CYCLES-1 with hold=0 and no other requester → counter <= 0, owner kept, no switch_pulse.
  - BLANK: grant=0, disp_enable=0, disp_data=FFFF_FFFF, owner_id keeps the last owner. Lasts exactly BLANK_CYCLES cycles.
    - In the last BLANK cycle, arbitrate on the current req. A winner → SHOW; no req → IDLE.
    - The previous owner may win again if it is the only requester.
- Entry into SHOW: dwell counter <= 0, switch_pulse=1 for that first SHOW cycle only.
- Non-owner requests never preempt. They wait for dwell expiry or for the owner to release.
- hold has no effect in IDLE or BLANK.
- Reset asserted in any state returns all registers to reset values on the next edge; the mid-dwell page is discarded.

## Timing
- Request to display: req sampled in IDLE at cycle t → grant, disp_enable and switch_pulse at t+1. disp_data at t+1 equals the winner's data_in sampled at t.
- Data latency: in SHOW, a data_in change at t appears on disp_data at t+1.
- Page length: a page without hold lasts exactly DWELL_CYCLES cycles. Hold cycles extend it one-for-one.
- Dwell expiry to next page: BLANK occupies cycles t+1..t+BLANK_CYCLES after the expiry cycle t. The new SHOW starts at t+BLANK_CYCLES+1.
- Owner release: owner req low at t → BLANK from t+1; the display blanks one cycle after release.
- Simultaneous events:
  - Owner drop on the same cycle as dwell expiry is treated as release; outcome identical.
  - hold=1 on the expiry cycle: no transition.
- Width rules:
  - Dwell counter width = $clog2(DWELL_CYCLES); blank counter width = $clog2(BLANK_CYCLES+1).
  - Counters never exceed their terminal values.
  - The rr_ptr increment wraps modulo N_REQ; correct for non-power-of-two N_REQ.

## Test plan
All scenarios use N_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=2, data_in[i]=32'h1111_1111*(i+1).
- Reset check: assert reset 3 cycles with req=4'b1111 → all outputs at reset values throughout. First grant is to source 0 one cycle after reset deasserts.
- Single source: req=0001 at cycle 0.
  - Cycle 1: grant=0001, switch_pulse=1, disp_data=1111_1111.
  - Through cycle 40: no BLANK and no further switch_pulse.
  - data_in[0] changed to 0000_1234 at cycle 20 → disp_data=0000_1234 at cycle 21.
- Rotation: req=0101 constant from cycle 0.
  - Owner 0 on cycles 1–8, blank on cycles 9–10.
  - Owner 2 on cycles 11–18 with disp_data=3333_3333, blank on 19–20.
  - Owner 0 again at cycle 21; switch_pulse at cycles 1, 11 and 21 only.
- Hold: same stimulus as rotation, hold=1 on cycles 3–7. Owner 0 is shown through cycle 13, blank on 14–15, owner 2 from cycle 16.
- Early release: req=0011, with req[0] dropped at cycle 4. Blank on cycles 5–6, grant=0010 at cycle 7.
  - Then req=0 from cycle 10 → blank on 11–12, then IDLE at 13 with disp_enable=0.
- Reset mid-SHOW: owner 1 at dwell count 5, reset pulsed 1 cycle → next cycle IDLE, rr_ptr=0. With req=0010 held, the new grant to source 1 gets a fresh 8-cycle dwell.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin time-sharing of the 8-digit seven-segment driver between N_REQ sources.
// Each granted source is shown for a dwell period, with a blank gap between different pages.
module display_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned BLANK_CYCLES = 10_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [32*N_REQ-1:0]      data_in,
    input  logic                     hold,
    output logic [31:0]              disp_data,
    output logic                     disp_enable,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     switch_pulse
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(N_REQ - 1);
    localparam logic [31:0]        BLANK_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_nxt;
    logic [BLANK_W-1:0]   blank_cnt;
    logic [BLANK_W-1:0]   blank_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      rr_nxt;
    logic [ID_W-1:0]      owner_nxt;
    logic                 start;

    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      arb_cand;
    int unsigned          arb_k;

    logic [N_REQ-1:0]     owner_oh;
    logic                 owner_req;
    logic                 others_req;

    logic [N_REQ-1:0]     grant_nxt;
    logic [31:0]          disp_data_nxt;
    logic                 disp_enable_nxt;
    logic                 switch_nxt;

    logic [31:0]          src [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign src[g] = data_in[32*g +: 32];
    end

    // Round-robin search: first set req bit starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_cand  = '0;
        arb_k     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arb_k = 32'(rr_ptr) + i;
            if (arb_k >= N_REQ) begin
                arb_k = arb_k - N_REQ;
            end
            arb_cand = ID_W'(arb_k);
            if (!win_found && req[arb_cand]) begin
                win_found = 1'b1;
                win_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        owner_oh           = '0;
        owner_oh[owner_id] = 1'b1;
        owner_req          = req[owner_id];
        others_req         = |(req & ~owner_oh);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            dwell_cnt    <= '0;
            blank_cnt    <= '0;
            rr_ptr       <= '0;
            owner_id     <= '0;
            grant        <= '0;
            disp_enable  <= 1'b0;
            disp_data    <= BLANK_DATA;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            dwell_cnt    <= dwell_nxt;
            blank_cnt    <= blank_nxt;
            rr_ptr       <= rr_nxt;
            owner_id     <= owner_nxt;
            grant        <= grant_nxt;
            disp_enable  <= disp_enable_nxt;
            disp_data    <= disp_data_nxt;
            switch_pulse <= switch_nxt;
        end
    end

    // Next-state: owner release always wins over dwell expiry; hold only freezes SHOW.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        blank_nxt = blank_cnt;
        rr_nxt    = rr_ptr;
        owner_nxt = owner_id;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    start = 1'b1;
                end
            end
            SHOW: begin
                if (!owner_req || (dwell_cnt == DWELL_LAST && !hold && others_req)) begin
                    state_nxt = BLANK;
                    blank_nxt = '0;
                end else if (!hold) begin
                    dwell_nxt = (dwell_cnt == DWELL_LAST) ? '0 : dwell_cnt + DWELL_W'(1);
                end
            end
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    if (win_found) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    blank_nxt = blank_cnt + BLANK_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (start) begin
            state_nxt = SHOW;
            dwell_nxt = '0;
            owner_nxt = win_idx;
            rr_nxt    = (win_idx == ID_LAST) ? '0 : win_idx + ID_W'(1);
        end
    end

    // Output values for the next cycle, derived from the next state and owner.
    always_comb begin
        grant_nxt       = '0;
        disp_enable_nxt = 1'b0;
        disp_data_nxt   = BLANK_DATA;
        switch_nxt      = 1'b0;
        if (state_nxt == SHOW) begin
            grant_nxt[owner_nxt] = 1'b1;
            disp_enable_nxt      = 1'b1;
            disp_data_nxt        = src[owner_nxt];
            switch_nxt           = (state != SHOW);
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with N_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
// Cycle c is the interval after the c-th clock edge; inputs set in cycle c are seen at edge c+1.
module tb_display_arbiter;

    localparam logic [127:0] DATA_DEF = {32'h4444_4444, 32'h3333_3333,
                                         32'h2222_2222, 32'h1111_1111};
    localparam logic [31:0]  BLANK_D  = 32'hFFFF_FFFF;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] data_in;
    logic         hold;
    logic [31:0]  disp_data;
    logic         disp_enable;
    logic [3:0]   grant;
    logic [1:0]   owner_id;
    logic         switch_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    display_arbiter #(
        .N_REQ        (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .data_in      (data_in),
        .hold         (hold),
        .disp_data    (disp_data),
        .disp_enable  (disp_enable),
        .grant        (grant),
        .owner_id     (owner_id),
        .switch_pulse (switch_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] src_val(input int id);
        return 32'h1111_1111 * 32'(id + 1);
    endfunction

    // Compares every output against one expected page description.
    task automatic expect_page(input string tag, input int c, input logic [3:0] g,
                               input int id, input logic sw, input logic [31:0] d);
        string t;
        t = $sformatf("%s@%0d", tag, c);
        check({t, ".grant"},  32'(grant),        32'(g));
        check({t, ".enable"}, 32'(disp_enable),  32'(g != 4'b0000));
        check({t, ".data"},   disp_data,         d);
        check({t, ".owner"},  32'(owner_id),     32'(id));
        check({t, ".switch"}, 32'(switch_pulse), 32'(sw));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 4'b0000;
        hold    = 1'b0;
        data_in = DATA_DEF;
        step();
        step();
        reset   = 1'b0;
    endtask

    initial begin
        // Reset held with all sources requesting, then first grant to source 0.
        reset   = 1'b1;
        req     = 4'b1111;
        hold    = 1'b0;
        data_in = DATA_DEF;
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_page("reset", c, 4'b0000, 0, 1'b0, BLANK_D);
        end
        reset = 1'b0;
        step();
        expect_page("reset_first", 4, 4'b0001, 0, 1'b1, src_val(0));

        // Single source never rotates; data change follows one cycle later.
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            step();
            expect_page("single", c, 4'b0001, 0, c == 1,
                        (c <= 20) ? src_val(0) : 32'h0000_1234);
            if (c == 20) data_in[31:0] = 32'h0000_1234;
        end
        data_in = DATA_DEF;

        // Rotation between sources 0 and 2.
        do_reset();
        req = 4'b0101;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c <= 8)       expect_page("rot", c, 4'b0001, 0, c == 1, src_val(0));
            else if (c <= 10) expect_page("rot", c, 4'b0000, 0, 1'b0, BLANK_D);
            else if (c <= 18) expect_page("rot", c, 4'b0100, 2, c == 11, src_val(2));
            else if (c <= 20) expect_page("rot", c, 4'b0000, 2, 1'b0, BLANK_D);
            else              expect_page("rot", c, 4'b0001, 0, 1'b1, src_val(0));
        end

        // Hold on cycles 3..7 stretches the first page by five cycles.
        do_reset();
        req = 4'b0101;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c <= 13)      expect_page("hold", c, 4'b0001, 0, c == 1, src_val(0));
            else if (c <= 15) expect_page("hold", c, 4'b0000, 0, 1'b0, BLANK_D);
            else              expect_page("hold", c, 4'b0100, 2, c == 16, src_val(2));
            if (c == 3) hold = 1'b1;
            if (c == 8) hold = 1'b0;
        end

        // Early release, then all requests drop to IDLE, then a new request from IDLE.
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c <= 4)       expect_page("rel", c, 4'b0001, 0, c == 1, src_val(0));
            else if (c <= 6)  expect_page("rel", c, 4'b0000, 0, 1'b0, BLANK_D);
            else if (c <= 10) expect_page("rel", c, 4'b0010, 1, c == 7, src_val(1));
            else if (c <= 13) expect_page("rel", c, 4'b0000, 1, 1'b0, BLANK_D);
            else              expect_page("rel", c, 4'b1000, 3, 1'b1, src_val(3));
            if (c == 4)  req = 4'b0010;
            if (c == 10) req = 4'b0000;
            if (c == 13) req = 4'b1000;
        end

        // Reset in mid-dwell: rr_ptr back to 0 and a fresh full dwell for the new grant.
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c <= 6)       expect_page("midrst", c, 4'b0010, 1, c == 1, src_val(1));
            else if (c == 7)  expect_page("midrst", c, 4'b0000, 0, 1'b0, BLANK_D);
            else if (c <= 15) expect_page("midrst", c, 4'b0010, 1, c == 8, src_val(1));
            else if (c <= 17) expect_page("midrst", c, 4'b0000, 1, 1'b0, BLANK_D);
            else              expect_page("midrst", c, 4'b0100, 2, c == 18, src_val(2));
            if (c == 6) reset = 1'b1;
            if (c == 7) begin
                reset = 1'b0;
                req   = 4'b0110;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
